// File: rtl/m_seq_sync.sv
// m_seq_sync: acquires chip alignment to a 63-chip PN stream, then free-runs a local copy
// and counts chip errors while locked, dropping lock on too many errors per window.
module m_seq_sync #(
  parameter logic [5:0] TAP_MASK = 6'b110011,
  parameter int LOCK_CNT = 16,
  parameter int LOSS_ERR = 4,
  parameter int WINDOW = 63,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             din,
  input  logic             din_valid,
  input  logic             clr_cnt,
  output logic             lock,
  output logic             err_pulse,
  output logic             epoch,
  output logic             ref_bit,
  output logic [CNT_W-1:0] bit_cnt,
  output logic [CNT_W-1:0] bit_err_cnt
);
  typedef enum logic [1:0] {SEED, CHECK, LOCKED} state_t;
  state_t state;
  logic [5:0] h, h_n;
  logic [2:0] seed_cnt;
  logic [7:0] match_cnt, win_cnt, win_err;
  logic p, mis, run, inc, loss;
  assign p = ^(h & TAP_MASK);
  assign run = state != SEED;
  assign ref_bit = run & p;
  assign mis = din ^ p;
  // a mismatch in CHECK reseeds from the received chip instead of the prediction
  assign h_n = (state == LOCKED || (state == CHECK && !mis)) ? {p, h[5:1]} : {din, h[5:1]};
  assign inc = din_valid && state == LOCKED;
  assign loss = mis && ((win_err + 8'd1) == 8'(LOSS_ERR));
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state <= SEED;
      h <= '0;
      seed_cnt <= '0;
      match_cnt <= '0;
      win_cnt <= '0;
      win_err <= '0;
      lock <= 1'b0;
      err_pulse <= 1'b0;
      epoch <= 1'b0;
      bit_cnt <= '0;
      bit_err_cnt <= '0;
    end else begin
      err_pulse <= 1'b0;
      epoch <= 1'b0;
      bit_cnt <= clr_cnt ? '0 : (inc && ~&bit_cnt) ? bit_cnt + 1'b1 : bit_cnt;
      bit_err_cnt <= clr_cnt ? '0 : (inc && mis && ~&bit_err_cnt) ? bit_err_cnt + 1'b1 : bit_err_cnt;
      if (din_valid) begin
        h <= h_n;
        epoch <= run && h_n == 6'b011111;
        case (state)
          SEED:
            if (seed_cnt >= 3'd5 && h_n != 6'd0) begin
              state <= CHECK;
              seed_cnt <= '0;
              match_cnt <= '0;
            end else seed_cnt <= (seed_cnt == 3'd6) ? seed_cnt : seed_cnt + 3'd1;
          CHECK:
            if (mis) begin
              state <= SEED;
              seed_cnt <= 3'd1;
              match_cnt <= '0;
            end else if ((match_cnt + 8'd1) == 8'(LOCK_CNT)) begin
              state <= LOCKED;
              lock <= 1'b1;
              match_cnt <= '0;
            end else match_cnt <= match_cnt + 8'd1;
          default: begin
            err_pulse <= mis;
            if (loss) begin
              state <= SEED;
              lock <= 1'b0;
              seed_cnt <= '0;
              win_cnt <= '0;
              win_err <= '0;
            end else if ((win_cnt + 8'd1) == 8'(WINDOW)) begin
              win_cnt <= '0;
              win_err <= '0;
            end else begin
              win_cnt <= win_cnt + 8'd1;
              win_err <= win_err + {7'd0, mis};
            end
          end
        endcase
      end
    end
endmodule
